// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: PC register, 2-entry {pc, inst} prefetch buffer, redirect flush.
// Build option FETCH_BOUND_HALT_EN: halt at end of ROM instead of wrapping fetch_pc to 0.
`ifndef INST_ADDR_LENGTH
`define INST_ADDR_LENGTH 8
`endif
`ifndef INST_BUS_LENGTH
`define INST_BUS_LENGTH 16
`endif

module fetch_ctrl #(
  parameter int ROM_DEPTH = 38
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic                          redirect_i,
  input  logic [`INST_ADDR_LENGTH-1:0]  redirect_pc_i,
  output logic [`INST_ADDR_LENGTH-1:0]  imem_pc_o,
  input  logic [`INST_BUS_LENGTH-1:0]   imem_inst_i,
  output logic [`INST_BUS_LENGTH-1:0]   inst_o,
  output logic [`INST_ADDR_LENGTH-1:0]  inst_pc_o,
  output logic                          inst_valid_o,
  input  logic                          inst_ready_i,
  output logic                          halt_o,
  output logic [1:0]                    buf_cnt_o
);
  localparam int AW = `INST_ADDR_LENGTH;
  localparam int IW = `INST_BUS_LENGTH;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] pc_q   [2];
  logic [AW-1:0] pc_d   [2];
  logic [IW-1:0] inst_q [2];
  logic [IW-1:0] inst_d [2];
  logic          run, in_rom, pop, push, wr_hi;

`ifdef FETCH_BOUND_HALT_EN
  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;
  state_e state_q, state_d;
  assign run    = (state_q == S_RUN);
  assign halt_o = (state_q == S_HALT);
`else
  localparam logic [AW-1:0] LAST_PC = AW'(ROM_DEPTH - 1);
  assign run    = 1'b1;
  assign halt_o = 1'b0;
`endif

  assign in_rom = (32'(fetch_pc_q) < ROM_DEPTH);
  assign pop    = inst_valid_o && inst_ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    push       = 1'b0;
    wr_hi      = 1'b0;
`ifdef FETCH_BOUND_HALT_EN
    state_d    = state_q;
`endif
    if (redirect_i) begin
      // Flush wins over any same-edge pop or push.
      cnt_d      = '0;
      fetch_pc_d = redirect_pc_i;
`ifdef FETCH_BOUND_HALT_EN
      state_d    = S_RUN;
`endif
    end else begin
      if (run && !in_rom) begin
`ifdef FETCH_BOUND_HALT_EN
        state_d    = S_HALT;
`else
        fetch_pc_d = '0;
`endif
      end else if (run && en_i && (cnt_q != 2'd2 || pop)) begin
        push = 1'b1;
`ifdef FETCH_BOUND_HALT_EN
        fetch_pc_d = fetch_pc_q + 1'b1;
`else
        fetch_pc_d = (fetch_pc_q == LAST_PC) ? '0 : fetch_pc_q + 1'b1;
`endif
      end
      if (pop) begin
        pc_d[0]   = pc_q[1];
        inst_d[0] = inst_q[1];
      end
      if (push) begin
        // Slot to write is the first free one after the shift caused by a pop.
        wr_hi = pop ? (cnt_q == 2'd2) : (cnt_q == 2'd1);
        if (wr_hi) begin
          pc_d[1]   = fetch_pc_q;
          inst_d[1] = imem_inst_i;
        end else begin
          pc_d[0]   = fetch_pc_q;
          inst_d[0] = imem_inst_i;
        end
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
`ifdef FETCH_BOUND_HALT_EN
      state_q    <= S_RUN;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
`ifdef FETCH_BOUND_HALT_EN
      state_q    <= state_d;
`endif
    end
  end

  assign imem_pc_o    = fetch_pc_q;
  assign buf_cnt_o    = cnt_q;
  assign inst_valid_o = (cnt_q != 2'd0);
  assign inst_o       = inst_valid_o ? inst_q[0] : '0;
  assign inst_pc_o    = inst_valid_o ? pc_q[0] : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios push expected PCs, a monitor checks accepted entries.
`ifndef INST_ADDR_LENGTH
`define INST_ADDR_LENGTH 8
`endif
`ifndef INST_BUS_LENGTH
`define INST_BUS_LENGTH 16
`endif

module tb_fetch_ctrl;
  localparam int AW = `INST_ADDR_LENGTH;
  localparam int IW = `INST_BUS_LENGTH;
`ifdef FETCH_BOUND_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk, rst_n, en, redirect, inst_ready;
  logic [AW-1:0] redirect_pc, imem_pc, inst_pc;
  logic [IW-1:0] imem_inst, inst;
  logic          inst_valid, halt;
  logic [1:0]    buf_cnt;

  logic [IW-1:0] rom [2**AW];
  logic [AW-1:0] exp_q [$];
  int            checks = 0;
  int            errors = 0;

  fetch_ctrl #(.ROM_DEPTH(38)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_pc_o(imem_pc), .imem_inst_i(imem_inst),
    .inst_o(inst), .inst_pc_o(inst_pc), .inst_valid_o(inst_valid),
    .inst_ready_i(inst_ready), .halt_o(halt), .buf_cnt_o(buf_cnt)
  );

  assign imem_inst = rom[imem_pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    exp_q.delete();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_imem_pc"}, 32'(imem_pc), 0);
    check({tag, "_inst"}, 32'(inst), 0);
    check({tag, "_inst_pc"}, 32'(inst_pc), 0);
    check({tag, "_valid"}, 32'(inst_valid), 0);
    check({tag, "_halt"}, 32'(halt), 0);
    check({tag, "_cnt"}, 32'(buf_cnt), 0);
  endtask

  // Monitor: every accepted head entry (valid & ready, not flushed) must match the queue front.
  always @(negedge clk) begin : monitor
    logic [AW-1:0] e;
    if (rst_n && inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual_pc=%0d expected=none", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", 32'(inst_pc), 32'(e));
        check("pop_inst", 32'(inst), 32'(rom[e]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) rom[i] = IW'(16'h4000 + i * 7);
    rom[0]  = 16'h8800;
    rom[24] = 16'hBA62;
    rst_n = 1'b0; en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Streaming 0..9 with ready held high
    en = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(AW'(i));
    tick();
    check("stream_pc0", 32'(inst_pc), 0);
    check("stream_inst0", 32'(inst), 32'h8800);
    check("stream_valid0", 32'(inst_valid), 1);
    repeat (9) tick();
    en = 1'b0;
    repeat (3) tick();
    check("stream_leftover", 32'(exp_q.size()), 0);
    check("stream_cnt", 32'(buf_cnt), 0);

    // Backpressure: fill to 2, stall, then release with no gap
    reset_dut();
    en = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(AW'(i));
    repeat (5) tick();
    check("stall_cnt", 32'(buf_cnt), 2);
    check("stall_fetch_pc", 32'(imem_pc), 2);
    inst_ready = 1'b1;
    repeat (4) begin
      tick();
      check("stall_nogap_valid", 32'(inst_valid), 1);
    end
    en = 1'b0;
    repeat (3) tick();
    check("stall_leftover", 32'(exp_q.size()), 0);

    // Redirect flush with buffer holding 22,23
    reset_dut();
    en = 1'b1; inst_ready = 1'b0; redirect = 1'b1; redirect_pc = AW'(22);
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    check("flush_pre_cnt", 32'(buf_cnt), 2);
    check("flush_pre_head", 32'(inst_pc), 22);
    redirect = 1'b1; redirect_pc = AW'(24);
    tick();
    check("flush_cnt", 32'(buf_cnt), 0);
    check("flush_imem_pc", 32'(imem_pc), 24);
    redirect = 1'b0; inst_ready = 1'b1;
    exp_q.push_back(AW'(24));
    exp_q.push_back(AW'(25));
    tick();
    check("flush_target_pc", 32'(inst_pc), 24);
    check("flush_target_inst", 32'(inst), 32'hBA62);
    tick();
    en = 1'b0;
    repeat (2) tick();
    check("flush_leftover", 32'(exp_q.size()), 0);

    // End of ROM: halt or wrap
    reset_dut();
    en = 1'b1; inst_ready = 1'b1; redirect = 1'b1; redirect_pc = AW'(35);
    exp_q.push_back(AW'(35));
    exp_q.push_back(AW'(36));
    exp_q.push_back(AW'(37));
    if (!HALT_EN) exp_q.push_back(AW'(0));
    tick();
    redirect = 1'b0;
    repeat (4) tick();
    en = 1'b0;
    repeat (2) tick();
    check("end_halt", 32'(halt), HALT_EN ? 1 : 0);
    check("end_fetch_pc", 32'(imem_pc), HALT_EN ? 38 : 1);
    check("end_valid", 32'(inst_valid), 0);
    check("end_leftover", 32'(exp_q.size()), 0);
    redirect = 1'b1; redirect_pc = AW'(5); en = 1'b1;
    exp_q.push_back(AW'(5));
    tick();
    check("resume_halt", 32'(halt), 0);
    check("resume_imem_pc", 32'(imem_pc), 5);
    check("resume_valid", 32'(inst_valid), 0);
    redirect = 1'b0;
    tick();
    check("resume_pc", 32'(inst_pc), 5);
    en = 1'b0;
    repeat (2) tick();
    check("resume_leftover", 32'(exp_q.size()), 0);

    // Redirect beyond ROM: handled the cycle after the load
    redirect = 1'b1; redirect_pc = AW'(40); en = 1'b1;
    tick();
    check("oob_imem_pc", 32'(imem_pc), 40);
    redirect = 1'b0;
    tick();
    en = 1'b0;
    check("oob_halt", 32'(halt), HALT_EN ? 1 : 0);
    check("oob_fetch_pc", 32'(imem_pc), HALT_EN ? 40 : 0);
    check("oob_cnt", 32'(buf_cnt), 0);
    tick();
    check("oob_cnt_after", 32'(buf_cnt), 0);

    // Async reset mid-cycle with a full buffer
    reset_dut();
    en = 1'b1; inst_ready = 1'b0;
    repeat (3) tick();
    check("midrst_pre_cnt", 32'(buf_cnt), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    en = 1'b0;
    #1;
    rst_n = 1'b1;
    en = 1'b1; inst_ready = 1'b1;
    exp_q.push_back(AW'(0));
    tick();
    check("midrst_first_pc", 32'(inst_pc), 0);
    en = 1'b0;
    repeat (2) tick();
    check("midrst_leftover", 32'(exp_q.size()), 0);

    // Push, pop and redirect together at count 1
    reset_dut();
    en = 1'b1; inst_ready = 1'b0;
    tick();
    check("ppr_pre_cnt", 32'(buf_cnt), 1);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = AW'(10);
    tick();
    check("ppr_cnt", 32'(buf_cnt), 0);
    check("ppr_valid", 32'(inst_valid), 0);
    redirect = 1'b0;
    exp_q.push_back(AW'(10));
    tick();
    check("ppr_next_pc", 32'(inst_pc), 10);
    en = 1'b0;
    repeat (2) tick();
    check("ppr_leftover", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
